// File: rtl/int_dispatch_queue_pkg.sv
// Shared CPU parameters, the renamed-uop type, and dispatch-queue helpers.
// Build option: INT_DQ_BYPASS_EN (see int_dispatch_queue.sv).
package cpu_params;
  localparam int CDB_WIDTH    = 2;
  localparam int PRF_IDX      = 6;
  localparam int ROB_IDX      = 5;
  localparam int FU_OP_W      = 4;
  localparam int INT_DQ_DEPTH = 4;
  localparam int INT_DQ_IDX   = $clog2(INT_DQ_DEPTH);
endpackage

package uop_types;
  import cpu_params::*;

  typedef struct packed {
    logic [PRF_IDX-1:0] rs1_phy;
    logic [PRF_IDX-1:0] rs2_phy;
    logic               rs1_valid;
    logic               rs2_valid;
    logic [PRF_IDX-1:0] rd_phy;
    logic [ROB_IDX-1:0] rob_id;
    logic [FU_OP_W-1:0] fu_opcode;
  } uop_t;
endpackage

package int_dispatch_queue_pkg;
  import cpu_params::*;

  // True when any valid CDB port broadcasts the given physical register.
  function automatic logic cdb_hit(input logic [CDB_WIDTH-1:0]              valid,
                                   input logic [CDB_WIDTH-1:0][PRF_IDX-1:0] rd_phy,
                                   input logic [PRF_IDX-1:0]                phy);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (valid[k] && (rd_phy[k] == phy)) hit = 1'b1;
    end
    return hit;
  endfunction
endpackage

// File: rtl/int_dispatch_queue_if.sv
// Rename-side push, RS-side dispatch and CDB snoop signals of the dispatch queue.
// master = the queue itself, slave = its environment (rename, RS, CDB).
interface int_dispatch_queue_if
  import cpu_params::*, uop_types::*;
  ;
  logic                              in_valid;
  logic                              in_ready;
  uop_t                              in_uop;
  logic                              out_valid;
  logic                              out_ready;
  uop_t                              out_uop;
  logic [CDB_WIDTH-1:0]              cdb_valid;
  logic [CDB_WIDTH-1:0][PRF_IDX-1:0] cdb_rd_phy;

  modport master (
    input  in_valid, in_uop, out_ready, cdb_valid, cdb_rd_phy,
    output in_ready, out_valid, out_uop
  );

  modport slave (
    output in_valid, in_uop, out_ready, cdb_valid, cdb_rd_phy,
    input  in_ready, out_valid, out_uop
  );
endinterface

// File: rtl/int_dispatch_queue_uop_wakeup.sv
// Combinational CDB wakeup: sets rs1_valid/rs2_valid of one uop on a
// matching broadcast. Bits are only ever OR'ed, never cleared.
module uop_wakeup
  import cpu_params::*, uop_types::*, int_dispatch_queue_pkg::*;
(
  input  uop_t                              uop,
  input  logic [CDB_WIDTH-1:0]              cdb_valid,
  input  logic [CDB_WIDTH-1:0][PRF_IDX-1:0] cdb_rd_phy,
  output uop_t                              woken
);
  always_comb begin
    woken           = uop;
    woken.rs1_valid = uop.rs1_valid | cdb_hit(cdb_valid, cdb_rd_phy, uop.rs1_phy);
    woken.rs2_valid = uop.rs2_valid | cdb_hit(cdb_valid, cdb_rd_phy, uop.rs2_phy);
  end
endmodule

// File: rtl/int_dispatch_queue.sv
// In-order dispatch FIFO feeding the integer RS, snooping the CDB every cycle.
// Define INT_DQ_BYPASS_EN to let an empty queue forward in_uop in the same cycle.
module int_dispatch_queue
  import cpu_params::*, uop_types::*, int_dispatch_queue_pkg::*;
#(
  parameter int DEPTH = INT_DQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  int_dispatch_queue_if.master     dq,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int IDX = $clog2(DEPTH);

  uop_t           entries       [DEPTH];
  uop_t           entries_woken [DEPTH];
  uop_t           in_woken;
  uop_t           head_uop;
  uop_t           head_woken;
  logic [IDX:0]   head;
  logic [IDX:0]   tail;
  logic           empty;
  logic           full;
  logic           push;
  logic           pop;
  logic           bypass;

  // Extra MSB is the wrap bit: equal indices with differing wrap bits means full.
  assign empty = (head == tail);
  assign full  = (head[IDX-1:0] == tail[IDX-1:0]) && (head[IDX] != tail[IDX]);
  assign count = tail - head;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry_wakeup
    uop_wakeup u_wakeup (
      .uop        (entries[i]),
      .cdb_valid  (dq.cdb_valid),
      .cdb_rd_phy (dq.cdb_rd_phy),
      .woken      (entries_woken[i])
    );
  end

  uop_wakeup u_in_wakeup (
    .uop        (dq.in_uop),
    .cdb_valid  (dq.cdb_valid),
    .cdb_rd_phy (dq.cdb_rd_phy),
    .woken      (in_woken)
  );

  assign head_uop = entries[head[IDX-1:0]];

  uop_wakeup u_head_wakeup (
    .uop        (head_uop),
    .cdb_valid  (dq.cdb_valid),
    .cdb_rd_phy (dq.cdb_rd_phy),
    .woken      (head_woken)
  );

`ifdef INT_DQ_BYPASS_EN
  // A bypassed uop goes straight to the RS and never occupies an entry.
  assign bypass = empty && dq.in_valid && dq.out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign dq.in_ready  = !full;
  assign dq.out_valid = !empty || bypass;
  assign dq.out_uop   = bypass ? in_woken : head_woken;

  assign push = dq.in_valid && !full && !bypass;
  assign pop  = dq.out_ready && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
    end
  end

  // Stored uops absorb each cycle's broadcasts; the tail slot takes the woken push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (tail[IDX-1:0] == IDX'(i))) entries[i] <= in_woken;
      else                                   entries[i] <= entries_woken[i];
    end
  end
endmodule

// File: tb/tb_int_dispatch_queue.sv
// Directed self-checking bench for int_dispatch_queue (DEPTH=4, CDB_WIDTH=2).
module tb_int_dispatch_queue;
  import cpu_params::*, uop_types::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] count;
  int         tests = 0;
  int         fails = 0;

  int_dispatch_queue_if dq ();

  int_dispatch_queue u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .dq    (dq.master),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic uop_t mk(input int rob, input int rs1, input bit v1,
                              input int rs2, input bit v2);
    uop_t u;
    u.rs1_phy   = PRF_IDX'(rs1);
    u.rs2_phy   = PRF_IDX'(rs2);
    u.rs1_valid = v1;
    u.rs2_valid = v2;
    u.rd_phy    = PRF_IDX'(rob + 32);
    u.rob_id    = ROB_IDX'(rob);
    u.fu_opcode = 4'h1;
    return u;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    dq.in_valid = 1'b1;
    dq.in_uop = mk(5, 1, 1, 2, 1);
    tick();
    tick();
    tests++; if (dq.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", dq.in_ready); end
    tests++; if (dq.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", dq.out_valid); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    rst_n = 1'b1;
    tick();
    dq.in_valid = 1'b0;
    #1;
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL post_reset_count got %0d want 1", count); end
    tests++; if (dq.out_valid !== 1'b1 || dq.out_uop.rob_id !== 5'd5)
      begin fails++; $display("FAIL post_reset_push got v=%b rob=%0d want v=1 rob=5", dq.out_valid, dq.out_uop.rob_id); end
    dq.out_ready = 1'b1;
    tick();
    dq.out_ready = 1'b0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL post_reset_drain got %0d want 0", count); end
  endtask

  task automatic test_fill_drain();
    for (int r = 0; r < 3; r++) begin
      dq.out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
        dq.in_valid = 1'b1;
        dq.in_uop = mk(i, 1, 1, 2, 1);
        tick();
      end
      dq.in_valid = 1'b0;
      #1;
      tests++; if (dq.in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready round %0d got %b want 0", r, dq.in_ready); end
      tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count round %0d got %0d want 4", r, count); end
      dq.out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
        #1;
        tests++; if (dq.out_valid !== 1'b1 || dq.out_uop.rob_id !== 5'(i))
          begin fails++; $display("FAIL drain_order round %0d got v=%b rob=%0d want v=1 rob=%0d", r, dq.out_valid, dq.out_uop.rob_id, i); end
        tick();
      end
      dq.out_ready = 1'b0;
      tests++; if (count !== 3'd0 || dq.out_valid !== 1'b0)
        begin fails++; $display("FAIL drain_empty round %0d got count=%0d v=%b want 0 0", r, count, dq.out_valid); end
    end
  endtask

  task automatic test_stale_wakeup();
    dq.out_ready = 1'b0;
    dq.in_valid = 1'b1;
    dq.in_uop = mk(7, 17, 0, 3, 1);
    tick();
    dq.in_valid = 1'b0;
    #1;
    tests++; if (dq.out_uop.rs1_valid !== 1'b0) begin fails++; $display("FAIL stale_pre got %b want 0", dq.out_uop.rs1_valid); end
    dq.cdb_valid = 2'b01;
    dq.cdb_rd_phy[0] = 6'd17;
    #1;
    tests++; if (dq.out_uop.rs1_valid !== 1'b1) begin fails++; $display("FAIL stale_same_cycle got %b want 1", dq.out_uop.rs1_valid); end
    tick();
    dq.cdb_valid = 2'b00;
    tick();
    dq.out_ready = 1'b1;
    #1;
    tests++; if (dq.out_valid !== 1'b1 || dq.out_uop.rs1_valid !== 1'b1 || dq.out_uop.rob_id !== 5'd7)
      begin fails++; $display("FAIL stale_stored got v=%b rs1v=%b rob=%0d want 1 1 7", dq.out_valid, dq.out_uop.rs1_valid, dq.out_uop.rob_id); end
    tick();
    dq.out_ready = 1'b0;
  endtask

  task automatic test_push_wakeup();
    dq.out_ready = 1'b0;
    dq.in_valid = 1'b1;
    dq.in_uop = mk(8, 2, 1, 9, 0);
    dq.cdb_valid = 2'b10;
    dq.cdb_rd_phy[1] = 6'd9;
    tick();
    dq.in_valid = 1'b0;
    dq.cdb_valid = 2'b00;
    #1;
    tests++; if (dq.out_uop.rs2_valid !== 1'b1 || dq.out_uop.rob_id !== 5'd8)
      begin fails++; $display("FAIL push_wakeup got rs2v=%b rob=%0d want 1 8", dq.out_uop.rs2_valid, dq.out_uop.rob_id); end
    dq.out_ready = 1'b1;
    tick();
    dq.out_ready = 1'b0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL push_wakeup_drain got %0d want 0", count); end
  endtask

  task automatic test_back_to_back();
    dq.out_ready = 1'b0;
    dq.in_valid = 1'b1;
    dq.in_uop = mk(10, 1, 1, 2, 1);
    tick();
    dq.in_uop = mk(11, 1, 1, 2, 1);
    tick();
    tests++; if (count !== 3'd2) begin fails++; $display("FAIL b2b_setup got %0d want 2", count); end
    dq.in_uop = mk(12, 1, 1, 2, 1);
    dq.out_ready = 1'b1;
    #1;
    tests++; if (dq.out_uop.rob_id !== 5'd10) begin fails++; $display("FAIL b2b_head got %0d want 10", dq.out_uop.rob_id); end
    tick();
    dq.in_valid = 1'b0;
    #1;
    tests++; if (count !== 3'd2) begin fails++; $display("FAIL b2b_count got %0d want 2", count); end
    tests++; if (dq.out_uop.rob_id !== 5'd11) begin fails++; $display("FAIL b2b_order1 got %0d want 11", dq.out_uop.rob_id); end
    tick();
    tests++; if (dq.out_uop.rob_id !== 5'd12) begin fails++; $display("FAIL b2b_order2 got %0d want 12", dq.out_uop.rob_id); end
    tick();
    dq.out_ready = 1'b0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL b2b_drain got %0d want 0", count); end
  endtask

  task automatic test_flush();
    dq.out_ready = 1'b0;
    for (int i = 20; i <= 22; i++) begin
      dq.in_valid = 1'b1;
      dq.in_uop = mk(i, 1, 1, 2, 1);
      tick();
    end
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL flush_setup got %0d want 3", count); end
    dq.in_uop = mk(23, 1, 1, 2, 1);
    dq.out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dq.in_valid = 1'b0;
    dq.out_ready = 1'b0;
    #1;
    tests++; if (count !== 3'd0 || dq.out_valid !== 1'b0 || dq.in_ready !== 1'b1)
      begin fails++; $display("FAIL flush_state got count=%0d v=%b rdy=%b want 0 0 1", count, dq.out_valid, dq.in_ready); end
    dq.in_valid = 1'b1;
    dq.in_uop = mk(24, 1, 1, 2, 1);
    tick();
    dq.in_valid = 1'b0;
    #1;
    tests++; if (count !== 3'd1 || dq.out_uop.rob_id !== 5'd24)
      begin fails++; $display("FAIL flush_after got count=%0d rob=%0d want 1 24", count, dq.out_uop.rob_id); end
    dq.out_ready = 1'b1;
    tick();
    dq.out_ready = 1'b0;
  endtask

  task automatic test_bypass();
    dq.in_valid = 1'b1;
    dq.in_uop = mk(30, 1, 1, 2, 1);
    dq.out_ready = 1'b1;
    #1;
`ifdef INT_DQ_BYPASS_EN
    tests++; if (dq.out_valid !== 1'b1 || dq.out_uop.rob_id !== 5'd30)
      begin fails++; $display("FAIL bypass_same_cycle got v=%b rob=%0d want 1 30", dq.out_valid, dq.out_uop.rob_id); end
    tick();
    dq.in_valid = 1'b0;
    dq.out_ready = 1'b0;
    #1;
    tests++; if (count !== 3'd0 || dq.out_valid !== 1'b0)
      begin fails++; $display("FAIL bypass_count got count=%0d v=%b want 0 0", count, dq.out_valid); end
`else
    tests++; if (dq.out_valid !== 1'b0) begin fails++; $display("FAIL nobypass_same_cycle got %b want 0", dq.out_valid); end
    tick();
    dq.in_valid = 1'b0;
    dq.out_ready = 1'b0;
    #1;
    tests++; if (count !== 3'd1 || dq.out_valid !== 1'b1 || dq.out_uop.rob_id !== 5'd30)
      begin fails++; $display("FAIL nobypass_latency got count=%0d v=%b rob=%0d want 1 1 30", count, dq.out_valid, dq.out_uop.rob_id); end
    dq.out_ready = 1'b1;
    tick();
    dq.out_ready = 1'b0;
`endif
  endtask

  initial begin
    dq.in_valid   = 1'b0;
    dq.in_uop     = '0;
    dq.out_ready  = 1'b0;
    dq.cdb_valid  = '0;
    dq.cdb_rd_phy = '0;
    test_reset();
    test_fill_drain();
    test_stale_wakeup();
    test_push_wakeup();
    test_back_to_back();
    test_flush();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
